// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: opcodes, one-hot ALU operators,
// FSM encoding, response payload and default ALU latency.
package alu_pkg;

    localparam int unsigned NUM_W    = 5;
    localparam int unsigned OUT_W    = 32;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned OPER_W   = 6;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned TXN_W    = 8;
    localparam int unsigned DEFAULT_ALU_LATENCY = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_CNT = 3'd3,
        OP_XOR = 3'd4,
        OP_MAX = 3'd5
    } op_e;

    // One-hot operator codes, identical to the ALU's decode
    localparam logic [OPER_W-1:0] OPER_ADD  = 6'b000001;
    localparam logic [OPER_W-1:0] OPER_SUB  = 6'b000010;
    localparam logic [OPER_W-1:0] OPER_MUL  = 6'b000100;
    localparam logic [OPER_W-1:0] OPER_CNT  = 6'b001000;
    localparam logic [OPER_W-1:0] OPER_XOR  = 6'b010000;
    localparam logic [OPER_W-1:0] OPER_MAX  = 6'b100000;
    localparam logic [OPER_W-1:0] OPER_NONE = 6'b000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [OUT_W-1:0] result;
        logic             odd;
        logic             equal;
        logic             err;
        logic [OP_W-1:0]  op;
    } rsp_t;

endpackage

// File: rtl/alu_op_encoder.sv
// Maps the 3-bit request opcode onto the ALU's one-hot operator; flags opcodes 6/7.
module alu_op_encoder
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    output logic [OPER_W-1:0] operator_c,
    output logic              illegal_c
);

    always_comb begin
        operator_c = OPER_NONE;
        illegal_c  = 1'b0;
        case (op)
            OP_ADD:  operator_c = OPER_ADD;
            OP_SUB:  operator_c = OPER_SUB;
            OP_MUL:  operator_c = OPER_MUL;
            OP_CNT:  operator_c = OPER_CNT;
            OP_XOR:  operator_c = OPER_XOR;
            OP_MAX:  operator_c = OPER_MAX;
            default: illegal_c  = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues one command at a time to a fixed-latency ALU, waits out the latency,
// captures the result and presents it on a valid/ready response port.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int unsigned ALU_LATENCY = DEFAULT_ALU_LATENCY
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [4:0]        req_num1,
    input  logic [4:0]        req_num2,

    output logic [4:0]        alu_num1,
    output logic [4:0]        alu_num2,
    output logic [5:0]        alu_operator,
    input  logic [31:0]       alu_out,
    input  logic              alu_odd_balance,
    input  logic              alu_equality,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_result,
    output logic              rsp_odd,
    output logic              rsp_equal,
    output logic              rsp_err,
    output logic [2:0]        rsp_op,

    output logic [7:0]        txn_count
);

    state_e             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               pend_err;
    rsp_t               rsp_q;
    logic [OPER_W-1:0]  enc_operator_c;
    logic               enc_illegal_c;

    alu_op_encoder u_enc (
        .op         (req_op),
        .operator_c (enc_operator_c),
        .illegal_c  (enc_illegal_c)
    );

    // Illegal opcodes still pass through WAIT for one edge (counter 0) so the
    // error response appears one edge after acceptance, without touching the ALU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            pend_err     <= 1'b0;
            alu_num1     <= '0;
            alu_num2     <= '0;
            alu_operator <= OPER_NONE;
            rsp_q        <= '0;
            rsp_valid    <= 1'b0;
            req_ready    <= 1'b1;
            txn_count    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        state     <= ST_WAIT;
                        req_ready <= 1'b0;
                        rsp_q.op  <= req_op;
                        pend_err  <= enc_illegal_c;
                        if (enc_illegal_c) begin
                            wait_cnt <= '0;
                        end else begin
                            wait_cnt     <= CNT_W'(ALU_LATENCY);
                            alu_num1     <= req_num1;
                            alu_num2     <= req_num2;
                            alu_operator <= enc_operator_c;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_q.err <= pend_err;
                        if (pend_err) begin
                            rsp_q.result <= '0;
                            rsp_q.odd    <= 1'b0;
                            rsp_q.equal  <= 1'b0;
                        end else begin
                            rsp_q.result <= alu_out;
                            rsp_q.odd    <= alu_odd_balance;
                            rsp_q.equal  <= alu_equality;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        txn_count <= txn_count + TXN_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign rsp_result = rsp_q.result;
    assign rsp_odd    = rsp_q.odd;
    assign rsp_equal  = rsp_q.equal;
    assign rsp_err    = rsp_q.err;
    assign rsp_op     = rsp_q.op;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: behavioural 2-cycle ALU, scoreboard of
// expected responses, latency/hold/backpressure/reset/wrap scenarios.
module tb_alu_cmd_issuer;

    localparam int unsigned LAT = 2;

    typedef struct {
        logic [31:0] result;
        logic        odd;
        logic        equal;
        logic        err;
        logic [2:0]  op;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [4:0]  req_num1;
    logic [4:0]  req_num2;
    logic [4:0]  alu_num1;
    logic [4:0]  alu_num2;
    logic [5:0]  alu_operator;
    logic [31:0] alu_out;
    logic        alu_odd_balance;
    logic        alu_equality;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_odd;
    logic        rsp_equal;
    logic        rsp_err;
    logic [2:0]  rsp_op;
    logic [7:0]  txn_count;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    logic [4:0] m_num1;
    logic [4:0] m_num2;
    logic [5:0] m_oper;
    logic [7:0] exp_cnt;

    alu_cmd_issuer #(.ALU_LATENCY(LAT)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_num1        (req_num1),
        .req_num2        (req_num2),
        .alu_num1        (alu_num1),
        .alu_num2        (alu_num2),
        .alu_operator    (alu_operator),
        .alu_out         (alu_out),
        .alu_odd_balance (alu_odd_balance),
        .alu_equality    (alu_equality),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_result      (rsp_result),
        .rsp_odd         (rsp_odd),
        .rsp_equal       (rsp_equal),
        .rsp_err         (rsp_err),
        .rsp_op          (rsp_op),
        .txn_count       (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: two register stages between operands and outputs
    logic [31:0] a_comb, s1, s2;
    logic        e1, e2;
    always_comb begin
        a_comb = '0;
        case (alu_operator)
            6'b000001: a_comb = 32'(alu_num1) + 32'(alu_num2);
            6'b000010: a_comb = 32'(alu_num1) - 32'(alu_num2);
            6'b000100: a_comb = 32'(alu_num1) * 32'(alu_num2);
            6'b001000: a_comb = 32'($countones(alu_num1));
            6'b010000: a_comb = 32'(alu_num1 ^ alu_num2);
            6'b100000: a_comb = (alu_num1 > alu_num2) ? 32'(alu_num1) : 32'(alu_num2);
            default:   a_comb = '0;
        endcase
    end
    always @(posedge clk) begin
        s1 <= a_comb;
        e1 <= (alu_num1 == alu_num2);
        s2 <= s1;
        e2 <= e1;
    end
    assign alu_out         = s2;
    assign alu_odd_balance = ^s2;
    assign alu_equality    = e2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t expect_of(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b);
        exp_t e;
        int   pc;
        e.op = op;
        e.err = 1'b0;
        e.result = '0;
        case (op)
            3'd0: e.result = 32'(a) + 32'(b);
            3'd1: e.result = 32'(a) - 32'(b);
            3'd2: e.result = 32'(a) * 32'(b);
            3'd3: begin
                pc = 0;
                for (int i = 0; i < 5; i++) pc += int'(a[i]);
                e.result = 32'(pc);
            end
            3'd4: e.result = {27'b0, a ^ b};
            3'd5: e.result = (a >= b) ? {27'b0, a} : {27'b0, b};
            default: e.err = 1'b1;
        endcase
        e.odd   = e.err ? 1'b0 : ^e.result;
        e.equal = e.err ? 1'b0 : (a == b);
        return e;
    endfunction

    task automatic run_txn(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b, input int hold);
        exp_t e;
        int n;
        logic legal;
        logic [31:0] snap_res;
        logic [5:0]  snap_flags;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_num1 = a; req_num2 = b;
        sb.push_back(expect_of(op, a, b));
        legal = (op <= 3'd5);
        if (legal) begin
            m_num1 = a; m_num2 = b; m_oper = 6'(1) << op;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 3'($urandom); req_num1 = 5'($urandom); req_num2 = 5'($urandom);
        chk("alu_operator_e0", 32'(alu_operator), 32'(m_oper));
        chk("alu_nums_e0", {22'b0, alu_num1, alu_num2}, {22'b0, m_num1, m_num2});
        n = 0;
        while (!rsp_valid && n < 20) begin
            chk("req_ready_busy", 32'(req_ready), 32'(0));
            @(posedge clk); #1; n++;
            chk("alu_hold", {16'b0, alu_operator, alu_num1, alu_num2}, {16'b0, m_oper, m_num1, m_num2});
        end
        chk("rsp_latency", 32'(n), legal ? 32'(LAT + 1) : 32'(1));
        snap_res   = rsp_result;
        snap_flags = {rsp_odd, rsp_equal, rsp_err, rsp_op};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(rsp_valid), 32'(1));
            chk("bp_ready", 32'(req_ready), 32'(0));
            chk("bp_result", rsp_result, snap_res);
            chk("bp_flags", 32'({rsp_odd, rsp_equal, rsp_err, rsp_op}), 32'(snap_flags));
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'(0), 32'(1));
        end else begin
            e = sb.pop_front();
            chk("rsp_result", rsp_result, e.result);
            chk("rsp_odd", 32'(rsp_odd), 32'(e.odd));
            chk("rsp_equal", 32'(rsp_equal), 32'(e.equal));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("rsp_op", 32'(rsp_op), 32'(e.op));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        chk("rsp_valid_drop", 32'(rsp_valid), 32'(0));
        chk("req_ready_idle", 32'(req_ready), 32'(1));
        chk("txn_count", 32'(txn_count), 32'(exp_cnt));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_num1 = '0; req_num2 = '0; rsp_ready = 1'b0;
        m_num1 = '0; m_num2 = '0; m_oper = '0; exp_cnt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_alu_operator", 32'(alu_operator), 32'(0));
        chk("rst_alu_nums", {22'b0, alu_num1, alu_num2}, 32'(0));
        chk("rst_payload", rsp_result | 32'({rsp_odd, rsp_equal, rsp_err, rsp_op}), 32'(0));
        chk("rst_txn_count", 32'(txn_count), 32'(0));
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("req_ready_after_rst", 32'(req_ready), 32'(1));

        run_txn(3'd0, 5'd7, 5'd9, 0);     // add
        run_txn(3'd2, 5'd5, 5'd5, 0);     // equal mul
        run_txn(3'd7, 5'd11, 5'd2, 0);    // illegal, ALU untouched
        run_txn(3'd1, 5'd20, 5'd3, 5);    // sub with backpressure
        run_txn(3'd1, 5'd3, 5'd20, 0);    // sub wrapping below zero
        run_txn(3'd3, 5'd29, 5'd0, 0);    // one-bit count
        run_txn(3'd5, 5'd4, 5'd30, 2);    // bigger number
        run_txn(3'd6, 5'd1, 5'd1, 0);     // illegal 6

        // Reset in the middle of WAIT discards the transaction
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd1; req_num1 = 5'd20; req_num2 = 5'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_alu_operator", 32'(alu_operator), 32'(0));
        chk("arst_alu_nums", {22'b0, alu_num1, alu_num2}, 32'(0));
        chk("arst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("arst_payload", rsp_result | 32'({rsp_odd, rsp_equal, rsp_err, rsp_op}), 32'(0));
        chk("arst_txn_count", 32'(txn_count), 32'(0));
        @(negedge clk); rst = 1'b0;
        m_num1 = '0; m_num2 = '0; m_oper = '0; exp_cnt = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("arst_no_rsp", 32'(rsp_valid), 32'(0));
        end
        chk("arst_txn_after", 32'(txn_count), 32'(0));
        rsp_ready = 1'b0;

        // 256 back-to-back xor transactions: counter wraps to zero
        for (int t = 0; t < 256; t++) begin
            run_txn(3'd4, 5'($urandom), 5'($urandom), 0);
        end
        chk("txn_wrap", 32'(txn_count), 32'(0));
        chk("sb_empty", 32'(sb.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
